alu_stack_sequencer: RTL and testbench
======================================

// Module: alu_stack_sequencer
// PURPOSE
//  Sequences one ALU operation against the operand stack: pops operands, drives the ALU,
//  pushes z and latches Flags. Sits between instruction decode (command side) and the
//  16-bit ALU plus stack memory. One command in flight; no operand forwarding.
// PARAMETERS
//  DATA_W   16  operand/result width (matches ALU x, y, z)
//  DEPTH_W  5   width of the stack depth count input
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  cmd_valid    in   1        command request
//  cmd_ready    out  1        high only in IDLE; a command is accepted on valid&ready
//  cmd_op       in   3        ALOP: CPY=0 ADD=1 NEGY=2 OR=3 NOTY=4 CPX=5 INX=6 DCX=7
//  done         out  1        1-cycle pulse, same cycle as stk_push
//  err          out  1        1-cycle pulse on stack underflow; command dropped
//  stk_top      in   DATA_W   current top of stack; valid when stk_depth!=0
//  stk_depth    in   DEPTH_W  entries on stack; reflects pop/push the cycle after
//  stk_pop      out  1        1-cycle pop strobe
//  stk_push     out  1        1-cycle push strobe
//  stk_wr_data  out  DATA_W   push data (registered z)
//  alu_x        out  DATA_W   ALU x operand (register)
//  alu_y        out  DATA_W   ALU y operand (register)
//  alu_op       out  3        ALU ALOP (register)
//  alu_z        in   DATA_W   ALU result (combinational from alu_x/alu_y/alu_op)
//  alu_flags    in   4        ALU Flags {OF,ZF,CF,SF} = bits [3:0]
//  flags        out  4        architectural flags, updated only in EXEC
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1 once rst_n high; done,err,stk_pop,stk_push=0;
//   alu_x,alu_y,stk_wr_data,flags=0; alu_op=CPY. Reset mid-command aborts with no push;
//   operands already popped are lost.
//  Operand classes: ADD,OR need 2 (top->y, next->x); NEGY,NOTY,CPY need 1 (top->y);
//   CPX,INX,DCX need 1 (top->x). Unused operand register keeps previous value.
//  FSM: IDLE -> (accept) CHECK -> POP1 -> [POP2 if binary] -> EXEC -> [RES] -> PUSH -> IDLE.
//   CHECK: stk_depth < needed -> ERR (err=1 one cycle, no pop) -> IDLE; else POP1.
//   POP1: capture stk_top into class register, stk_pop=1.
//   POP2: capture updated stk_top into alu_x, stk_pop=1.
//   EXEC: alu_op stable since CHECK; capture alu_z into stk_wr_data, alu_flags into flags.
//   PUSH: stk_push=1, done=1.
//  Latency accept->done: binary 5 cycles, unary 4 cycles (+1 with RES). Error: 2 cycles.
//  Net stack effect: binary -1, unary 0; a push never follows a failed check, so no overflow.
//  cmd_valid outside IDLE is ignored (not queued). Back-to-back: next accept in cycle after PUSH.
//  Arithmetic lives entirely in ALU; this block never modifies z or flags bits.
// CONFIGURATION
//  ALU_SEQ_RESREG_EN defined: RES state inserted after EXEC; EXEC only waits, RES captures
//   alu_z/alu_flags, giving the ALU a full extra cycle (latency +1).
//  Undefined: no RES state; capture in EXEC, latencies as above.
// STRUCTURE
//  Package alu_seq_pkg: ALOP localparams (CPY..DCX), flag indices SF=0 CF=1 ZF=2 OF=3,
//   state enum, function operand_count(op) returning 1 or 2.
//  Single module, no sub-module; FSM and operand registers are small enough inline.
// TESTING
//  depth=3 top=0x3997 next=0x04B0, ADD -> pops 2, push 0x3E47, flags=0, done at accept+5.
//  depth=1 top=0x0001, NEGY -> push 0xFFFF, flags SF=1, depth net 0, done at accept+4.
//  depth=1 top=0xFFFF, INX -> push 0x0000, ZF=1 CF=1; alu_y unchanged from prior value.
//  depth=1, OR -> err pulse accept+2, no stk_pop/stk_push, flags unchanged, cmd_ready back.
//  rst_n low during POP2 -> outputs to reset values same cycle, no push; next ADD runs clean.
//  ALU_SEQ_RESREG_EN on: repeat ADD case -> same result, done at accept+6.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU stack sequencer: ALU opcodes, flag bit
// positions, FSM state encoding and operand-class helpers.
package alu_seq_pkg;

  localparam int unsigned ALOP_W  = 3;
  localparam int unsigned FLAGS_W = 4;

  localparam logic [ALOP_W-1:0] ALOP_CPY  = 3'd0;
  localparam logic [ALOP_W-1:0] ALOP_ADD  = 3'd1;
  localparam logic [ALOP_W-1:0] ALOP_NEGY = 3'd2;
  localparam logic [ALOP_W-1:0] ALOP_OR   = 3'd3;
  localparam logic [ALOP_W-1:0] ALOP_NOTY = 3'd4;
  localparam logic [ALOP_W-1:0] ALOP_CPX  = 3'd5;
  localparam logic [ALOP_W-1:0] ALOP_INX  = 3'd6;
  localparam logic [ALOP_W-1:0] ALOP_DCX  = 3'd7;

  localparam int unsigned FLAG_SF = 0;
  localparam int unsigned FLAG_CF = 1;
  localparam int unsigned FLAG_ZF = 2;
  localparam int unsigned FLAG_OF = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_POP1  = 3'd2,
    ST_POP2  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_RES   = 3'd5,
    ST_PUSH  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  // Number of stack operands an ALU op consumes.
  function automatic logic [1:0] operand_count(input logic [ALOP_W-1:0] op);
    return ((op == ALOP_ADD) || (op == ALOP_OR)) ? 2'd2 : 2'd1;
  endfunction

  // Unary ops on x take their single operand into alu_x instead of alu_y.
  function automatic logic top_to_x(input logic [ALOP_W-1:0] op);
    return (op == ALOP_CPX) || (op == ALOP_INX) || (op == ALOP_DCX);
  endfunction

endpackage

// File: rtl/alu_stack_sequencer.sv
// Sequences one ALU operation against the operand stack: checks depth, pops
// operands into the ALU operand registers, captures the result and flags,
// then pushes the result. Optional macro ALU_SEQ_RESREG_EN inserts a RES
// state after EXEC so the ALU gets a full extra cycle before capture.
module alu_stack_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  output logic               done,
  output logic               err,
  input  logic [DATA_W-1:0]  stk_top,
  input  logic [DEPTH_W-1:0] stk_depth,
  output logic               stk_pop,
  output logic               stk_push,
  output logic [DATA_W-1:0]  stk_wr_data,
  output logic [DATA_W-1:0]  alu_x,
  output logic [DATA_W-1:0]  alu_y,
  output logic [2:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_z,
  input  logic [3:0]         alu_flags,
  output logic [3:0]         flags
);

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   alu_x_nxt;
  logic [DATA_W-1:0]   alu_y_nxt;
  logic [2:0]          alu_op_nxt;
  logic [DATA_W-1:0]   wr_data_nxt;
  logic [3:0]          flags_nxt;

  // Next-state, operand capture and result capture.
  always_comb begin
    state_nxt   = state;
    alu_x_nxt   = alu_x;
    alu_y_nxt   = alu_y;
    alu_op_nxt  = alu_op;
    wr_data_nxt = stk_wr_data;
    flags_nxt   = flags;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt  = ST_CHECK;
          alu_op_nxt = cmd_op;
        end
      end
      ST_CHECK: begin
        if (stk_depth < DEPTH_W'(operand_count(alu_op))) state_nxt = ST_ERR;
        else                                             state_nxt = ST_POP1;
      end
      ST_POP1: begin
        if (top_to_x(alu_op)) alu_x_nxt = stk_top;
        else                  alu_y_nxt = stk_top;
        state_nxt = (operand_count(alu_op) == 2'd2) ? ST_POP2 : ST_EXEC;
      end
      ST_POP2: begin
        alu_x_nxt = stk_top;
        state_nxt = ST_EXEC;
      end
`ifdef ALU_SEQ_RESREG_EN
      ST_EXEC: state_nxt = ST_RES;
      ST_RES: begin
        wr_data_nxt = alu_z;
        flags_nxt   = alu_flags;
        state_nxt   = ST_PUSH;
      end
`else
      ST_EXEC: begin
        wr_data_nxt = alu_z;
        flags_nxt   = alu_flags;
        state_nxt   = ST_PUSH;
      end
`endif
      ST_PUSH: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and strobes; strobes are decoded from the next state so
  // they are registered yet coincide with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      stk_pop     <= 1'b0;
      stk_push    <= 1'b0;
      stk_wr_data <= '0;
      alu_x       <= '0;
      alu_y       <= '0;
      alu_op      <= ALOP_CPY;
      flags       <= '0;
    end else begin
      state       <= state_nxt;
      cmd_ready   <= (state_nxt == ST_IDLE);
      done        <= (state_nxt == ST_PUSH);
      err         <= (state_nxt == ST_ERR);
      stk_pop     <= (state_nxt == ST_POP1) || (state_nxt == ST_POP2);
      stk_push    <= (state_nxt == ST_PUSH);
      stk_wr_data <= wr_data_nxt;
      alu_x       <= alu_x_nxt;
      alu_y       <= alu_y_nxt;
      alu_op      <= alu_op_nxt;
      flags       <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// Directed bench for alu_stack_sequencer with a behavioural stack and ALU.
module tb_alu_stack_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_RESREG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        done;
  logic        err;
  logic [15:0] stk_top;
  logic [4:0]  stk_depth;
  logic        stk_pop;
  logic        stk_push;
  logic [15:0] stk_wr_data;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [2:0]  alu_op;
  logic [15:0] alu_z;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  // stack model and preload port
  logic [15:0] mem [0:31];
  logic [4:0]  depth_m = 5'd0;
  logic        ld_req = 1'b0;
  logic [4:0]  ld_depth = 5'd0;
  logic [15:0] ld_mem [0:3];

  always #5 clk = ~clk;

  alu_stack_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .done(done), .err(err), .stk_top(stk_top),
    .stk_depth(stk_depth), .stk_pop(stk_pop), .stk_push(stk_push),
    .stk_wr_data(stk_wr_data), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_z(alu_z), .alu_flags(alu_flags), .flags(flags)
  );

  assign stk_depth = depth_m;
  assign stk_top   = (depth_m != 5'd0) ? mem[5'(depth_m - 5'd1)] : 16'h0000;

  // Stack memory: preload, pop, push.
  always @(posedge clk) begin
    if (ld_req) begin
      depth_m <= ld_depth;
      for (int i = 0; i < 4; i++) mem[i] <= ld_mem[i];
    end else if (stk_push) begin
      mem[depth_m] <= stk_wr_data;
      depth_m      <= depth_m + 5'd1;
    end else if (stk_pop && depth_m != 5'd0) begin
      depth_m <= depth_m - 5'd1;
    end
  end

  // Reference 16-bit ALU, flags {OF,ZF,CF,SF}.
  always_comb begin
    logic [16:0] s;
    logic cf, of;
    s  = 17'd0;
    cf = 1'b0;
    of = 1'b0;
    case (alu_op)
      ALOP_CPY:  s = {1'b0, alu_y};
      ALOP_ADD: begin
        s  = {1'b0, alu_x} + {1'b0, alu_y};
        cf = s[16];
        of = (alu_x[15] == alu_y[15]) && (s[15] != alu_x[15]);
      end
      ALOP_NEGY: begin
        s  = {1'b0, 16'(16'h0000 - alu_y)};
        of = (alu_y == 16'h8000);
      end
      ALOP_OR:   s = {1'b0, alu_x | alu_y};
      ALOP_NOTY: s = {1'b0, ~alu_y};
      ALOP_CPX:  s = {1'b0, alu_x};
      ALOP_INX: begin
        s  = {1'b0, alu_x} + 17'd1;
        cf = s[16];
        of = (alu_x == 16'h7FFF);
      end
      default: begin
        s  = {1'b0, 16'(alu_x - 16'h0001)};
        cf = (alu_x == 16'h0000);
        of = (alu_x == 16'h8000);
      end
    endcase
    alu_z     = s[15:0];
    alu_flags = {of, (s[15:0] == 16'h0000), cf, s[15]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] d, input logic [15:0] m0,
                         input logic [15:0] m1, input logic [15:0] m2);
    @(negedge clk);
    ld_depth  = d;
    ld_mem[0] = m0;
    ld_mem[1] = m1;
    ld_mem[2] = m2;
    ld_mem[3] = 16'h0000;
    ld_req    = 1'b1;
    @(negedge clk);
    ld_req    = 1'b0;
  endtask

  // Issue one command and observe 10 cycles; cycle numbers count from accept.
  task automatic run_cmd(input logic [2:0] op, input bit hold,
                         output int done_at, output int err_at, output int pops,
                         output int pushes, output int done_cnt);
    done_at = 0; err_at = 0; pops = 0; pushes = 0; done_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (stk_pop)  pops++;
      if (stk_push) pushes++;
      if (done) begin done_cnt++; if (done_at == 0) done_at = n; end
      if (err && err_at == 0) err_at = n;
      if (hold && n < 3) cmd_op = ALOP_ADD;
      else               cmd_valid = 1'b0;
    end
  endtask

  int d_at, e_at, np, nq, dc;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = ALOP_CPY;
    for (int i = 0; i < 4; i++) ld_mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_strobes", {done, err, stk_pop, stk_push}, 0);
    chk("rst_x", alu_x, 0);
    chk("rst_y", alu_y, 0);
    chk("rst_wr", stk_wr_data, 0);
    chk("rst_op", alu_op, ALOP_CPY);
    chk("rst_flags", flags, 0);

    // binary ADD
    preload(5'd3, 16'h1111, 16'h04B0, 16'h3997);
    run_cmd(ALOP_ADD, 1'b0, d_at, e_at, np, nq, dc);
    chk("add_lat", d_at, 5 + EXTRA);
    chk("add_pops", np, 2);
    chk("add_push", nq, 1);
    chk("add_done_w", dc, 1);
    chk("add_wr", stk_wr_data, 16'h3E47);
    chk("add_flags", flags, 4'b0000);
    chk("add_depth", depth_m, 2);
    chk("add_top", stk_top, 16'h3E47);
    chk("add_ready", cmd_ready, 1);

    // unary NEGY on y
    preload(5'd1, 16'h0001, 16'h0000, 16'h0000);
    run_cmd(ALOP_NEGY, 1'b0, d_at, e_at, np, nq, dc);
    chk("negy_lat", d_at, 4 + EXTRA);
    chk("negy_pops", np, 1);
    chk("negy_wr", stk_wr_data, 16'hFFFF);
    chk("negy_flags", flags, 4'b0001);
    chk("negy_depth", depth_m, 1);
    chk("negy_x_kept", alu_x, 16'h04B0);

    // unary INX on x
    preload(5'd1, 16'hFFFF, 16'h0000, 16'h0000);
    run_cmd(ALOP_INX, 1'b0, d_at, e_at, np, nq, dc);
    chk("inx_lat", d_at, 4 + EXTRA);
    chk("inx_wr", stk_wr_data, 16'h0000);
    chk("inx_flags", flags, 4'b0110);
    chk("inx_x", alu_x, 16'hFFFF);
    chk("inx_y_kept", alu_y, 16'h0001);

    // underflow on binary OR
    preload(5'd1, 16'h1234, 16'h0000, 16'h0000);
    run_cmd(ALOP_OR, 1'b0, d_at, e_at, np, nq, dc);
    chk("or_err_at", e_at, 2);
    chk("or_no_pop", np, 0);
    chk("or_no_push", nq, 0);
    chk("or_no_done", dc, 0);
    chk("or_flags", flags, 4'b0110);
    chk("or_depth", depth_m, 1);
    chk("or_ready", cmd_ready, 1);

    // DCX with cmd_valid held busy and op changed mid-command
    preload(5'd1, 16'h0000, 16'h0000, 16'h0000);
    run_cmd(ALOP_DCX, 1'b1, d_at, e_at, np, nq, dc);
    chk("dcx_lat", d_at, 4 + EXTRA);
    chk("dcx_pops", np, 1);
    chk("dcx_push", nq, 1);
    chk("dcx_wr", stk_wr_data, 16'hFFFF);
    chk("dcx_flags", flags, 4'b0011);
    chk("dcx_op", alu_op, ALOP_DCX);

    // reset asserted during POP2
    preload(5'd3, 16'h1111, 16'h04B0, 16'h3997);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = ALOP_ADD;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("pop2_strobe", stk_pop, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {done, err, stk_pop, stk_push}, 0);
    chk("mid_rst_regs", {alu_x, alu_y}, 0);
    chk("mid_rst_op_flags", {alu_op, flags}, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    nq = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (stk_push) nq++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (stk_push) nq++;
    chk("mid_rst_no_push", nq, 0);
    chk("mid_rst_depth", depth_m, 2);

    preload(5'd3, 16'h1111, 16'h04B0, 16'h3997);
    run_cmd(ALOP_ADD, 1'b0, d_at, e_at, np, nq, dc);
    chk("add2_lat", d_at, 5 + EXTRA);
    chk("add2_pops", np, 2);
    chk("add2_wr", stk_wr_data, 16'h3E47);
    chk("add2_depth", depth_m, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
